// File: rtl/scs8hd_clkdly_pkg.sv
// Shared types and helpers for the scs8hd_clkdlybuf4s25 tap-select controller.
package scs8hd_clkdly_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    SETTLE,
    DONE
  } tapsel_state_e;

  localparam int unsigned TAPS_DEF       = 8;
  localparam int unsigned SETTLE_CYC_DEF = 4;

  // Out-of-range tap requests saturate at the last tap of the chain.
  function automatic int unsigned clamp_code(input int unsigned code, input int unsigned taps);
    return (code >= taps) ? taps - 1 : code;
  endfunction

endpackage

// File: rtl/scs8hd_clkdly_tapdec.sv
// Registered binary-to-one-hot decoder for the delay-chain tap mux; resets to tap 0.
module scs8hd_clkdly_tapdec #(
  parameter int unsigned N = 8,
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] bin,
  output logic [N-1:0] onehot
);

  logic [N-1:0] dec;

  always_comb begin
    dec = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (bin == W'(i)) dec[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) onehot <= N'(1);
    else     onehot <= dec;
  end

endmodule

// File: rtl/scs8hd_clkdly_tapsel_ctl.sv
// Tap-select controller: walks the delay-chain tap one step at a time with a settle window.
// Optional macro SCS8HD_TAPSEL_CLAMP_ERR_EN adds the clamp_err flag output.
module scs8hd_clkdly_tapsel_ctl
  import scs8hd_clkdly_pkg::*;
#(
  parameter int unsigned TAPS       = TAPS_DEF,
  parameter int unsigned CODE_W     = 3,
  parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF,
  parameter int unsigned CNT_W      = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req,
  input  logic [CODE_W-1:0] code,
  output logic              ack,
  output logic              busy,
  output logic [CODE_W-1:0] tap_code,
  output logic [TAPS-1:0]   tap_sel
`ifdef SCS8HD_TAPSEL_CLAMP_ERR_EN
  ,
  output logic              clamp_err
`endif
);

  tapsel_state_e     state;
  logic [CODE_W-1:0] target;
  logic [CODE_W-1:0] code_cl;
  logic [CODE_W-1:0] tap_next;
  logic [CNT_W-1:0]  cnt;

  assign code_cl = CODE_W'(clamp_code(32'(code), TAPS));

  // The next tap value feeds both the tap_code register and the one-hot
  // decoder, so tap_sel updates on the same edge as tap_code.
  always_comb begin
    tap_next = tap_code;
    if (state == STEP) begin
      tap_next = (target > tap_code) ? tap_code + CODE_W'(1) : tap_code - CODE_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= IDLE;
      tap_code  <= '0;
      target    <= '0;
      cnt       <= '0;
      ack       <= 1'b0;
      busy      <= 1'b0;
`ifdef SCS8HD_TAPSEL_CLAMP_ERR_EN
      clamp_err <= 1'b0;
`endif
    end else begin
      tap_code <= tap_next;
      ack      <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
`ifdef SCS8HD_TAPSEL_CLAMP_ERR_EN
            clamp_err <= (32'(code) >= TAPS);
`endif
            busy <= 1'b1;
            if (code_cl != tap_code) begin
              target <= code_cl;
              state  <= STEP;
            end else begin
              state <= DONE;
              ack   <= 1'b1;
            end
          end
        end
        STEP: begin
          cnt   <= CNT_W'(SETTLE_CYC - 1);
          state <= SETTLE;
        end
        SETTLE: begin
          if (cnt == '0) begin
            if (tap_code != target) begin
              state <= STEP;
            end else begin
              state <= DONE;
              ack   <= 1'b1;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  scs8hd_clkdly_tapdec #(
    .N (TAPS),
    .W (CODE_W)
  ) u_tapdec (
    .clk    (CLK),
    .rst    (RESET),
    .bin    (tap_next),
    .onehot (tap_sel)
  );

endmodule
